// File: rtl/ldtu_gsel_buffer_pkg.sv
// ldtu_gsel_pkg: gain-mode encodings and FSM states shared by the dual-gain selection buffer
package ldtu_gsel_pkg;
  typedef enum logic [1:0] {
    GSEL_AUTO      = 2'b00,
    GSEL_AUTO2     = 2'b01,
    GSEL_FORCE_X10 = 2'b10,
    GSEL_FORCE_X1  = 2'b11
  } gsel_mode_t;
  typedef logic [1:0] state_t;
  localparam state_t S_FILL  = 2'd0;
  localparam state_t S_RUN   = 2'd1;
  localparam state_t S_FLUSH = 2'd2;
  function automatic logic is_forced(input logic [1:0] mode);
    return mode[1];
  endfunction
endpackage

// File: rtl/ldtu_gsel_buffer_if.sv
// ldtu_gsel_buffer_if: sample-pair input and encoder-side output handshake
interface ldtu_gsel_buffer_if #(parameter int DW = 12);
  logic          in_valid;
  logic [DW-1:0] data_g1;
  logic [DW-1:0] data_g10;
  logic          out_ready;
  logic          out_valid;
  logic [DW:0]   out_data;
  logic          baseline_flag;
  modport master (output in_valid, data_g1, data_g10, out_ready, input out_valid, out_data, baseline_flag);
  modport slave  (input in_valid, data_g1, data_g10, out_ready, output out_valid, out_data, baseline_flag);
endinterface

// File: rtl/ldtu_gsel_buffer_ram.sv
// ldtu_gsel_ram: sample-pair register file, one write port, output and lookahead read ports
module ldtu_gsel_ram #(
  parameter int DW    = 12,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [2*DW-1:0] wdata,
  input  logic [AW-1:0]   raddr_a,
  output logic [2*DW-1:0] rdata_a,
  input  logic [AW-1:0]   raddr_b,
  output logic [DW-1:0]   rdata_b
);
  logic [2*DW-1:0] mem [DEPTH];
  // contents are not reset; validity is tracked by the pointers
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b][DW-1:0];
endmodule

// File: rtl/ldtu_gsel_buffer.sv
// ldtu_gsel_buffer: dual-gain lookahead buffer with x1 hold window; LDTU_GSEL_STATS_EN enables g1_count
module ldtu_gsel_buffer
  import ldtu_gsel_pkg::*;
#(
  parameter int DW        = 12,
  parameter int DEPTH     = 16,
  parameter int LOOKAHEAD = 3,
  parameter int WIN_MAX   = 16,
  parameter int BASE_BITS = 6,
  localparam int WW = $clog2(WIN_MAX + 1),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                 CLK,
  input  logic                 rst,
  ldtu_gsel_buffer_if.slave    bus,
  input  logic [DW-1:0]        sat_value,
  input  logic [1:0]           shift_g10,
  input  logic [1:0]           gain_sel_mode,
  input  logic [WW-1:0]        win_len,
  input  logic                 flush,
  output logic [CW-1:0]        fill_level,
  output logic                 overflow,
  output logic [15:0]          g1_count
);
  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, la_ptr;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] sat_q, sat_d;
  logic [WW:0]   hold_q, hold_d, win_eff, eff;
  logic          out_valid_q, out_valid_d, base_q, base_d, ovf_q, ovf_d;
  logic [DW:0]   out_data_q, out_data_d, new_data;
  logic [2*DW-1:0] rd_word;
  logic [DW-1:0] la_g10;
  logic          load_ok, avail, pop, push, sat, sel_x1, new_base;

  assign la_ptr = rd_ptr_q + AW'(LOOKAHEAD);

  ldtu_gsel_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk     (CLK),
    .we      (push),
    .waddr   (wr_ptr_q),
    .wdata   ({bus.data_g1, bus.data_g10 >> shift_g10}),
    .raddr_a (rd_ptr_q),
    .rdata_a (rd_word),
    .raddr_b (la_ptr),
    .rdata_b (la_g10)
  );

  // handshake, occupancy and pointer bookkeeping
  always_comb begin
    load_ok  = !out_valid_q || bus.out_ready;
    avail    = state_q == S_FLUSH ? count_q != '0 : count_q >= CW'(LOOKAHEAD + 1);
    pop      = load_ok && avail;
    push     = bus.in_valid && (count_q != CW'(DEPTH) || pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    ovf_d    = ovf_q || (bus.in_valid && !push);
    sat_d    = sat_value >> shift_g10;
  end

  // gain decision and output register load; the lookahead slot is meaningless while draining short
  always_comb begin
    sat        = !(state_q == S_FLUSH && count_q <= CW'(LOOKAHEAD)) && la_g10 >= sat_q;
    win_eff    = win_len == '0 ? (WW+1)'(1) : {1'b0, win_len};
    eff        = gain_sel_mode == GSEL_AUTO2 ? win_eff << 1 : win_eff;
    sel_x1     = is_forced(gain_sel_mode) ? gain_sel_mode == GSEL_FORCE_X1 : sat || hold_q != '0;
    hold_d     = !pop ? hold_q : is_forced(gain_sel_mode) ? '0 : sat ? eff - 1'b1 : hold_q != '0 ? hold_q - 1'b1 : hold_q;
    new_data   = sel_x1 ? {1'b1, rd_word[2*DW-1:DW]} : {1'b0, rd_word[DW-1:0]};
    new_base   = gain_sel_mode[1] ? new_data[DW-1:BASE_BITS] == '0 : new_data[DW:BASE_BITS] == '0;
    out_data_d = pop ? new_data : out_data_q;
    base_d     = pop ? new_base : base_q;
    out_valid_d = pop || (out_valid_q && !bus.out_ready);
  end

  // fill / run / flush sequencing
  always_comb begin
    state_d = state_q == S_FLUSH ? (count_d == '0 ? S_FILL : S_FLUSH)
            : flush && (state_q == S_RUN || count_q != '0) ? S_FLUSH
            : state_q == S_FILL && count_d >= CW'(LOOKAHEAD + 1) ? S_RUN
            : state_q;
  end

  // state registers
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= S_FILL;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sat_q       <= '1;
      hold_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      base_q      <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      hold_q      <= hold_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      base_q      <= base_d;
      ovf_q       <= ovf_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_data      = out_data_q;
  assign bus.baseline_flag = base_q;
  assign fill_level        = count_q;
  assign overflow          = ovf_q;

`ifdef LDTU_GSEL_STATS_EN
  logic [15:0] g1_cnt_q, g1_cnt_d;
  // saturating count of x1 selections
  always_comb begin
    g1_cnt_d = pop && sel_x1 && g1_cnt_q != 16'hFFFF ? g1_cnt_q + 16'd1 : g1_cnt_q;
  end
  // counter register
  always_ff @(posedge CLK) begin
    g1_cnt_q <= rst ? '0 : g1_cnt_d;
  end
  assign g1_count = g1_cnt_q;
`else
  assign g1_count = '0;
`endif
endmodule
